// File: rtl/ceas_pkg.sv
// Shared definitions for the clock's mode/alarm control path.
// Build option: SNOOZE_EN adds the SNOOZE state and widens the ring/snooze counter.
package ceas_pkg;

`ifdef SNOOZE_EN
    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_MIN,
        ST_SET_HOUR,
        ST_AL_MIN,
        ST_AL_HOUR,
        ST_RING,
        ST_SNOOZE
    } state_t;

    // Must hold SNOOZE_MIN*60 - 1 for the longest snooze (899).
    localparam int unsigned CNT_W = 10;
`else
    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_MIN,
        ST_SET_HOUR,
        ST_AL_MIN,
        ST_AL_HOUR,
        ST_RING
    } state_t;

    localparam int unsigned CNT_W = 8;
`endif

    // Largest legal BCD value of each time field.
    localparam logic [7:0]  MIN_MAX           = 8'h59;
    localparam logic [7:0]  HOUR_MAX          = 8'h23;

    // Alarm setpoint loaded at reset, BCD {H1,H0,M1,M0}.
    localparam logic [15:0] ALARM_RST_DEFAULT = 16'h0700;

endpackage

// File: rtl/bcd_field_inc.sv
// Two-digit BCD increment that wraps to 00 after MAX_VAL.
// Build option SNOOZE_EN has no effect on this block.
module bcd_field_inc
    import ceas_pkg::*;
#(
    parameter logic [7:0] MAX_VAL = MIN_MAX
) (
    input  logic [7:0] value,
    output logic [7:0] value_inc
);

    // At or beyond the limit wraps to 00, so a stray value never yields invalid BCD.
    always_comb begin
        value_inc = '0;
        if (value >= MAX_VAL) begin
            value_inc = '0;
        end else if (value[3:0] >= 4'd9) begin
            value_inc = {value[7:4] + 4'd1, 4'd0};
        end else begin
            value_inc = {value[7:4], value[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/alarm_mode_controller.sv
// Mode/alarm sequencer: drives the time counter's set/run controls, holds the
// alarm setpoint and raises alarm_bit while ringing.
// Build option: define SNOOZE_EN to enable the SNOOZE state (btn_inc while ringing).
module alarm_mode_controller
    import ceas_pkg::*;
#(
    parameter int unsigned RING_SECS  = 60,
    parameter int unsigned SNOOZE_MIN = 5,
    parameter logic [15:0] ALARM_RST  = ALARM_RST_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        btn_set,
    input  logic        btn_inc,
    input  logic        btn_start,
    input  logic [15:0] time_bcd,
    output logic        set_minute,
    output logic        set_ore,
    output logic        inc_out,
    output logic        run_en,
    output logic [15:0] alarm_bcd,
    output logic        alarm_armed,
    output logic        alarm_bit
);

    if (RING_SECS < 1 || RING_SECS > 255 || SNOOZE_MIN < 1 || SNOOZE_MIN > 15) begin : g_param_check
        $error("alarm_mode_controller: RING_SECS or SNOOZE_MIN out of range");
    end

    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECS - 1);
`ifdef SNOOZE_EN
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_MIN * 60 - 1);
`endif

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               match_prev;
    logic               match_now, match_edge;
    logic               armed_n, inc_out_n;
    logic [15:0]        alarm_n;
    logic [7:0]         min_inc, hour_inc;
    logic               set_p, start_p, inc_p;

    bcd_field_inc #(.MAX_VAL(MIN_MAX)) u_min_inc (
        .value     (alarm_bcd[7:0]),
        .value_inc (min_inc)
    );

    bcd_field_inc #(.MAX_VAL(HOUR_MAX)) u_hour_inc (
        .value     (alarm_bcd[15:8]),
        .value_inc (hour_inc)
    );

    // One button acts per cycle: set > start > inc.
    assign set_p   = btn_set;
    assign start_p = btn_start & ~btn_set;
    assign inc_p   = btn_inc & ~btn_set & ~btn_start;

    // Ring only on the first cycle of agreement, so a held minute cannot retrigger.
    assign match_now  = (time_bcd == alarm_bcd);
    assign match_edge = match_now & ~match_prev;

    // Next-state, counter and alarm-register logic.
    // In RUN a button pulse takes the cycle, so a match edge coinciding with one is dropped.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        armed_n   = alarm_armed;
        alarm_n   = alarm_bcd;
        inc_out_n = 1'b0;
        case (state)
            ST_RUN: begin
                if (set_p) begin
                    state_n = ST_SET_MIN;
                end else if (start_p) begin
                    armed_n = ~alarm_armed;
                end else if (alarm_armed && match_edge) begin
                    state_n = ST_RING;
                    cnt_n   = '0;
                end
            end
            ST_SET_MIN: begin
                if (set_p) begin
                    state_n = ST_SET_HOUR;
                end else if (inc_p) begin
                    inc_out_n = 1'b1;
                end
            end
            ST_SET_HOUR: begin
                if (set_p) begin
                    state_n = ST_AL_MIN;
                end else if (inc_p) begin
                    inc_out_n = 1'b1;
                end
            end
            ST_AL_MIN: begin
                if (set_p) begin
                    state_n = ST_AL_HOUR;
                end else if (start_p) begin
                    armed_n = ~alarm_armed;
                end else if (inc_p) begin
                    alarm_n[7:0] = min_inc;
                end
            end
            ST_AL_HOUR: begin
                if (set_p) begin
                    state_n = ST_RUN;
                end else if (start_p) begin
                    armed_n = ~alarm_armed;
                end else if (inc_p) begin
                    alarm_n[15:8] = hour_inc;
                end
            end
            ST_RING: begin
                if (set_p || start_p) begin
                    state_n = ST_RUN;
                    cnt_n   = '0;
`ifdef SNOOZE_EN
                end else if (inc_p) begin
                    state_n = ST_SNOOZE;
                    cnt_n   = '0;
`endif
                end else if (tick_1hz) begin
                    if (cnt == RING_LAST) begin
                        state_n = ST_RUN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
`ifdef SNOOZE_EN
            ST_SNOOZE: begin
                if (set_p || start_p) begin
                    state_n = ST_RUN;
                    cnt_n   = '0;
                end else if (tick_1hz) begin
                    if (cnt == SNOOZE_LAST) begin
                        state_n = ST_RING;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
`endif
            default: begin
                state_n = ST_RUN;
                cnt_n   = '0;
            end
        endcase
    end

    // State, counter and registered outputs, decoded from the next state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_RUN;
            cnt         <= '0;
            match_prev  <= 1'b0;
            alarm_bcd   <= ALARM_RST;
            alarm_armed <= 1'b0;
            set_minute  <= 1'b0;
            set_ore     <= 1'b0;
            inc_out     <= 1'b0;
            run_en      <= 1'b1;
            alarm_bit   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            match_prev  <= match_now;
            alarm_bcd   <= alarm_n;
            alarm_armed <= armed_n;
            set_minute  <= (state_n == ST_SET_MIN);
            set_ore     <= (state_n == ST_SET_HOUR);
            inc_out     <= inc_out_n;
            run_en      <= (state_n != ST_SET_MIN) && (state_n != ST_SET_HOUR);
            alarm_bit   <= (state_n == ST_RING);
        end
    end

endmodule

// File: tb/tb_alarm_mode_controller.sv
// Self-checking bench for alarm_mode_controller: vector table, directed
// ring/snooze sequences and a randomized run against an integer-level model.
// Build option: SNOOZE_EN enables the snooze sequences and model behaviour.
module tb_alarm_mode_controller;

    localparam int unsigned RING_SECS  = 60;
    localparam int unsigned SNOOZE_MIN = 5;
    localparam logic [15:0] ALARM_RST  = 16'h0700;
`ifdef SNOOZE_EN
    localparam bit SNOOZE_ON = 1'b1;
`else
    localparam bit SNOOZE_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tick_1hz = 1'b0;
    logic        btn_set = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_start = 1'b0;
    logic [15:0] time_bcd = 16'h1234;
    logic        set_minute, set_ore, inc_out, run_en, alarm_armed, alarm_bit;
    logic [15:0] alarm_bcd;

    alarm_mode_controller #(
        .RING_SECS  (RING_SECS),
        .SNOOZE_MIN (SNOOZE_MIN),
        .ALARM_RST  (ALARM_RST)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .btn_set     (btn_set),
        .btn_inc     (btn_inc),
        .btn_start   (btn_start),
        .time_bcd    (time_bcd),
        .set_minute  (set_minute),
        .set_ore     (set_ore),
        .inc_out     (inc_out),
        .run_en      (run_en),
        .alarm_bcd   (alarm_bcd),
        .alarm_armed (alarm_armed),
        .alarm_bit   (alarm_bit)
    );

    always #5 clock = ~clock;

    // Observation word: {set_minute, set_ore, inc_out, run_en, alarm_bit, alarm_armed, alarm_bcd}
    typedef logic [21:0] obs_t;
    localparam obs_t M_ALL = '1;
    localparam obs_t M_BIT = 22'h020000;
    localparam obs_t M_AL  = 22'h00FFFF;
    localparam obs_t M_RBA = 22'h270000; // set_minute, run_en, alarm_bit, alarm_armed

    int tests = 0;
    int fails = 0;

    function automatic obs_t mk(input bit sm, input bit so, input bit inc, input bit run,
                                input bit bt, input bit arm, input logic [15:0] al);
        return {sm, so, inc, run, bt, arm, al};
    endfunction

    function automatic obs_t dut_obs();
        return {set_minute, set_ore, inc_out, run_en, alarm_bit, alarm_armed, alarm_bcd};
    endfunction

    task automatic check(input string name, input obs_t mask, input obs_t exp);
        obs_t act;
        act = dut_obs();
        tests++;
        if ((act & mask) !== (exp & mask)) begin
            fails++;
            $display("FAIL %s: got sm/so/inc/run/bit/arm/al=%b%b%b%b%b%b/%h required %b%b%b%b%b%b/%h",
                     name, act[21], act[20], act[19], act[18], act[17], act[16], act[15:0],
                     exp[21], exp[20], exp[19], exp[18], exp[17], exp[16], exp[15:0]);
        end
    endtask

    // One clock cycle: drive at the falling edge, outputs settle by the next falling edge.
    task automatic cyc(input bit s, input bit i, input bit st, input bit tk);
        btn_set = s; btn_inc = i; btn_start = st; tick_1hz = tk;
        @(negedge clock);
        btn_set = 0; btn_inc = 0; btn_start = 0; tick_1hz = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(0, 0, 0, 0);
        reset = 1'b1;
    endtask

    // Reset, arm the alarm (07:00) and return to RUN with time away from the alarm.
    task automatic arm_and_run();
        time_bcd = 16'h1234;
        do_reset();
        repeat (3) cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (2) cyc(1, 0, 0, 0);
    endtask

    task automatic ring_now();
        time_bcd = 16'h0659;
        cyc(0, 0, 0, 0);
        time_bcd = 16'h0700;
        cyc(0, 0, 0, 0);
    endtask

    // ---------------- integer-level reference model ----------------
    int m_mode;          // 0 run, 1 set minutes, 2 set hours, 3 alarm minutes, 4 alarm hours
    bit m_ring, m_snooze, m_arm, m_prev, m_incp;
    int m_el, m_ah, m_am;

    function automatic logic [15:0] to_bcd(input int h, input int m);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ring = 0; m_snooze = 0; m_arm = 0; m_prev = 0; m_incp = 0; m_el = 0;
        m_ah = 10 * int'(ALARM_RST[15:12]) + int'(ALARM_RST[11:8]);
        m_am = 10 * int'(ALARM_RST[7:4]) + int'(ALARM_RST[3:0]);
    endtask

    task automatic model_step(input bit s, input bit i, input bit st, input bit tk,
                              input int th, input int tm);
        bit now_match, edge_seen;
        now_match = (th == m_ah) && (tm == m_am);
        edge_seen = now_match && !m_prev;
        m_prev = now_match;
        m_incp = 0;
        if (m_ring || m_snooze) begin
            if (s || st) begin
                m_ring = 0; m_snooze = 0; m_el = 0;
            end else if (m_ring && i && SNOOZE_ON) begin
                m_ring = 0; m_snooze = 1; m_el = 0;
            end else if (tk) begin
                m_el++;
                if (m_ring && m_el == int'(RING_SECS)) begin
                    m_ring = 0; m_el = 0;
                end else if (m_snooze && m_el == int'(SNOOZE_MIN) * 60) begin
                    m_snooze = 0; m_ring = 1; m_el = 0;
                end
            end
        end else if (s) begin
            m_mode = (m_mode + 1) % 5;
        end else if (st) begin
            if (m_mode == 0 || m_mode >= 3) m_arm = !m_arm;
        end else if (m_mode == 0) begin
            if (m_arm && edge_seen) begin
                m_ring = 1; m_el = 0;
            end
        end else if (i) begin
            if (m_mode == 1 || m_mode == 2) m_incp = 1;
            else if (m_mode == 3) m_am = (m_am + 1) % 60;
            else m_ah = (m_ah + 1) % 24;
        end
    endtask

    function automatic obs_t model_obs();
        return mk(m_mode == 1, m_mode == 2, m_incp, !(m_mode == 1 || m_mode == 2),
                  m_ring, m_arm, to_bcd(m_ah, m_am));
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        bit   s, i, st, tk;
        obs_t exp;
    } vec_t;

    vec_t vecs[18];

    task automatic setv(input int n, input bit s, input bit i, input bit st, input bit tk, input obs_t e);
        vecs[n].s = s; vecs[n].i = i; vecs[n].st = st; vecs[n].tk = tk; vecs[n].exp = e;
    endtask

    initial begin
        int th, tm, r;
        bit s, i, st, tk;

        setv(0,  1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 16'h0700));
        setv(1,  0, 1, 0, 0, mk(1, 0, 1, 0, 0, 0, 16'h0700));
        setv(2,  0, 0, 0, 1, mk(1, 0, 0, 0, 0, 0, 16'h0700));
        setv(3,  0, 1, 0, 0, mk(1, 0, 1, 0, 0, 0, 16'h0700));
        setv(4,  0, 1, 0, 0, mk(1, 0, 1, 0, 0, 0, 16'h0700));
        setv(5,  0, 1, 1, 0, mk(1, 0, 0, 0, 0, 0, 16'h0700));
        setv(6,  1, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 16'h0700));
        setv(7,  0, 1, 0, 0, mk(0, 1, 1, 0, 0, 0, 16'h0700));
        setv(8,  1, 0, 0, 0, mk(0, 0, 0, 1, 0, 0, 16'h0700));
        setv(9,  0, 1, 0, 0, mk(0, 0, 0, 1, 0, 0, 16'h0701));
        setv(10, 0, 0, 1, 0, mk(0, 0, 0, 1, 0, 1, 16'h0701));
        setv(11, 1, 1, 0, 0, mk(0, 0, 0, 1, 0, 1, 16'h0701));
        setv(12, 0, 1, 0, 0, mk(0, 0, 0, 1, 0, 1, 16'h0801));
        setv(13, 0, 0, 1, 0, mk(0, 0, 0, 1, 0, 0, 16'h0801));
        setv(14, 1, 0, 0, 0, mk(0, 0, 0, 1, 0, 0, 16'h0801));
        setv(15, 0, 0, 1, 0, mk(0, 0, 0, 1, 0, 1, 16'h0801));
        setv(16, 0, 1, 0, 0, mk(0, 0, 0, 1, 0, 1, 16'h0801));
        setv(17, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 1, 16'h0801));

        @(negedge clock);

        // Reset state
        do_reset();
        check("reset_state", M_ALL, mk(0, 0, 0, 1, 0, 0, 16'h0700));

        // Mode walk, inc pulses, arm toggles, priority
        for (int n = 0; n < 18; n++) begin
            cyc(vecs[n].s, vecs[n].i, vecs[n].st, vecs[n].tk);
            check($sformatf("vec%0d", n), M_ALL, vecs[n].exp);
        end

        // Field wrap: 23:59 -> 00:59 -> 00:00
        do_reset();
        repeat (3) cyc(1, 0, 0, 0);
        repeat (59) cyc(0, 1, 0, 0);
        check("min_to_59", M_AL, mk(0, 0, 0, 0, 0, 0, 16'h0759));
        cyc(1, 0, 0, 0);
        repeat (16) cyc(0, 1, 0, 0);
        check("alarm_2359", M_AL, mk(0, 0, 0, 0, 0, 0, 16'h2359));
        cyc(0, 1, 0, 0);
        check("hour_wrap", M_AL, mk(0, 0, 0, 0, 0, 0, 16'h0059));
        repeat (4) cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        check("min_wrap", M_AL, mk(0, 0, 0, 0, 0, 0, 16'h0000));

        // Match edge, ring duration, no retrigger
        arm_and_run();
        check("armed_run", M_ALL, mk(0, 0, 0, 1, 0, 1, 16'h0700));
        ring_now();
        check("ring_start", M_BIT, mk(0, 0, 0, 0, 1, 0, 16'h0));
        repeat (59) cyc(0, 0, 0, 1);
        check("ring_59s", M_BIT, mk(0, 0, 0, 0, 1, 0, 16'h0));
        cyc(0, 0, 0, 1);
        check("ring_timeout", M_RBA, mk(0, 0, 0, 1, 0, 1, 16'h0));
        repeat (5) cyc(0, 0, 0, 1);
        check("no_retrigger", M_BIT, mk(0, 0, 0, 0, 0, 0, 16'h0));

        // Dismiss with set+inc: no advance, no snooze, armed kept
        ring_now();
        check("ring2_start", M_BIT, mk(0, 0, 0, 0, 1, 0, 16'h0));
        cyc(1, 1, 0, 0);
        check("dismiss_set", M_RBA, mk(0, 0, 0, 1, 0, 1, 16'h0));
        repeat (3) cyc(0, 0, 0, 1);
        check("after_dismiss", M_RBA, mk(0, 0, 0, 1, 0, 1, 16'h0));

        // Dismiss coinciding with tick; next ring starts from a cleared count
        ring_now();
        repeat (10) cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 1);
        check("dismiss_tick", M_RBA, mk(0, 0, 0, 1, 0, 1, 16'h0));
        ring_now();
        repeat (59) cyc(0, 0, 0, 1);
        check("count_cleared", M_BIT, mk(0, 0, 0, 0, 1, 0, 16'h0));
        cyc(0, 0, 0, 1);
        check("ring3_timeout", M_BIT, mk(0, 0, 0, 0, 0, 0, 16'h0));

        // btn_inc while ringing
        ring_now();
`ifdef SNOOZE_EN
        cyc(0, 1, 0, 0);
        check("snooze_enter", M_RBA, mk(0, 0, 0, 1, 0, 1, 16'h0));
        repeat (299) cyc(0, 0, 0, 1);
        check("snooze_299", M_BIT, mk(0, 0, 0, 0, 0, 0, 16'h0));
        cyc(0, 0, 0, 1);
        check("snooze_rering", M_BIT, mk(0, 0, 0, 0, 1, 0, 16'h0));
        cyc(0, 1, 0, 0);
        do_reset();
        check("reset_in_snooze", M_ALL, mk(0, 0, 0, 1, 0, 0, 16'h0700));
`else
        cyc(0, 1, 0, 0);
        check("inc_in_ring", M_RBA, mk(0, 0, 0, 1, 1, 1, 16'h0));
        do_reset();
        check("reset_in_ring", M_ALL, mk(0, 0, 0, 1, 0, 0, 16'h0700));
`endif

        // Randomized run against the model
        th = 12; tm = 34;
        time_bcd = to_bcd(th, tm);
        do_reset();
        model_reset();
        for (int n = 0; n < 6000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                if (m_am == 0) begin
                    tm = 59; th = (m_ah + 23) % 24;
                end else begin
                    tm = m_am - 1; th = m_ah;
                end
            end else if (r < 16) begin
                th = m_ah; tm = m_am;
            end else if (r < 20) begin
                th = int'($urandom_range(0, 23)); tm = int'($urandom_range(0, 59));
            end
            time_bcd = to_bcd(th, tm);
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
                model_reset();
                m_prev = 0;
            end else begin
                s  = ($urandom_range(0, 19) == 0);
                i  = ($urandom_range(0, 5) == 0);
                st = ($urandom_range(0, 24) == 0);
                tk = ($urandom_range(0, 2) == 0);
                model_step(s, i, st, tk, th, tm);
                cyc(s, i, st, tk);
            end
            check($sformatf("rand%0d", n), M_ALL, model_obs());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
